// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand selection and optional EX/MEM and MEM/WB forwarding.
// Define ID_EX_FORWARDING_EN to enable forwarding; otherwise operands come straight from the register file read.
module id_ex_stage #(
   parameter int RA_W = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall,
   input  logic            flush,
   input  logic            id_valid,
   input  logic [3:0]      id_alu_op,
   input  logic            id_reg_write,
   input  logic [RA_W-1:0] id_rd_addr,
   input  logic [RA_W-1:0] id_rs_addr,
   input  logic [RA_W-1:0] id_rt_addr,
   input  logic [31:0]     id_rs_data,
   input  logic [31:0]     id_rt_data,
   input  logic [15:0]     id_imm,
   input  logic [4:0]      id_shamt,
   input  logic            id_alu_src_imm,
   input  logic            id_imm_zext,
   input  logic            id_shift_shamt,
   input  logic            exm_reg_write,
   input  logic [RA_W-1:0] exm_rd_addr,
   input  logic [31:0]     exm_result,
   input  logic            mwb_reg_write,
   input  logic [RA_W-1:0] mwb_rd_addr,
   input  logic [31:0]     mwb_data,
   output logic            ex_valid,
   output logic [31:0]     ex_oprd1,
   output logic [31:0]     ex_oprd2,
   output logic [3:0]      ex_option,
   output logic [RA_W-1:0] ex_rd_addr,
   output logic            ex_reg_write,
   output logic [31:0]     ex_store_data
);

   logic            valid_p1;
   logic [3:0]      alu_op_p1;
   logic            reg_write_p1;
   logic [RA_W-1:0] rd_addr_p1;
   logic [RA_W-1:0] rs_addr_p1;
   logic [RA_W-1:0] rt_addr_p1;
   logic [31:0]     rs_data_p1;
   logic [31:0]     rt_data_p1;
   logic [15:0]     imm_p1;
   logic [4:0]      shamt_p1;
   logic            alu_src_imm_p1;
   logic            imm_zext_p1;
   logic            shift_shamt_p1;

   // ID -> EX boundary: flush beats stall, reset beats both
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n || flush) begin
         valid_p1       <= 1'b0;
         alu_op_p1      <= 4'b0000;
         reg_write_p1   <= 1'b0;
         rd_addr_p1     <= '0;
         rs_addr_p1     <= '0;
         rt_addr_p1     <= '0;
         rs_data_p1     <= '0;
         rt_data_p1     <= '0;
         imm_p1         <= '0;
         shamt_p1       <= '0;
         alu_src_imm_p1 <= 1'b0;
         imm_zext_p1    <= 1'b0;
         shift_shamt_p1 <= 1'b0;
      end else if (!stall) begin
         valid_p1       <= id_valid;
         alu_op_p1      <= id_alu_op;
         reg_write_p1   <= id_reg_write;
         rd_addr_p1     <= id_rd_addr;
         rs_addr_p1     <= id_rs_addr;
         rt_addr_p1     <= id_rt_addr;
         rs_data_p1     <= id_rs_data;
         rt_data_p1     <= id_rt_data;
         imm_p1         <= id_imm;
         shamt_p1       <= id_shamt;
         alu_src_imm_p1 <= id_alu_src_imm;
         imm_zext_p1    <= id_imm_zext;
         shift_shamt_p1 <= id_shift_shamt;
      end
   end

   logic [31:0] fwd_rs;
   logic [31:0] fwd_rt;
   logic [31:0] imm_ext;

`ifdef ID_EX_FORWARDING_EN
   // Youngest producer wins; register 0 is hardwired and never forwarded.
   function automatic logic [31:0] forward(input logic [RA_W-1:0] addr,
                                           input logic [31:0]     reg_data);
      if (exm_reg_write && exm_rd_addr == addr && addr != '0)
         return exm_result;
      else if (mwb_reg_write && mwb_rd_addr == addr && addr != '0)
         return mwb_data;
      else
         return reg_data;
   endfunction

   assign fwd_rs = forward(rs_addr_p1, rs_data_p1);
   assign fwd_rt = forward(rt_addr_p1, rt_data_p1);
`else
   logic unused_fwd;
   assign unused_fwd = ^{exm_reg_write, exm_rd_addr, exm_result, mwb_reg_write,
                         mwb_rd_addr, mwb_data, rs_addr_p1, rt_addr_p1};
   assign fwd_rs = rs_data_p1;
   assign fwd_rt = rt_data_p1;
`endif

   assign imm_ext = imm_zext_p1 ? {16'b0, imm_p1} : {{16{imm_p1[15]}}, imm_p1};

   always_comb begin
      ex_oprd1 = fwd_rs;
      ex_oprd2 = alu_src_imm_p1 ? imm_ext : fwd_rt;
      if (shift_shamt_p1) begin
         ex_oprd1 = fwd_rt;
         ex_oprd2 = {27'b0, shamt_p1};
      end
   end

   assign ex_valid      = valid_p1;
   assign ex_option     = alu_op_p1;
   assign ex_rd_addr    = rd_addr_p1;
   assign ex_reg_write  = reg_write_p1 & valid_p1;
   assign ex_store_data = fwd_rt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed table-driven bench for id_ex_stage; expectations follow ID_EX_FORWARDING_EN.
module tb_id_ex_stage;

`ifdef ID_EX_FORWARDING_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall, flush;
   logic        id_valid, id_reg_write, id_alu_src_imm, id_imm_zext, id_shift_shamt;
   logic [3:0]  id_alu_op;
   logic [4:0]  id_rd_addr, id_rs_addr, id_rt_addr, id_shamt;
   logic [31:0] id_rs_data, id_rt_data;
   logic [15:0] id_imm;
   logic        exm_reg_write, mwb_reg_write;
   logic [4:0]  exm_rd_addr, mwb_rd_addr;
   logic [31:0] exm_result, mwb_data;
   logic        ex_valid, ex_reg_write;
   logic [31:0] ex_oprd1, ex_oprd2, ex_store_data;
   logic [3:0]  ex_option;
   logic [4:0]  ex_rd_addr;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   id_ex_stage #(.RA_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
      .id_valid(id_valid), .id_alu_op(id_alu_op), .id_reg_write(id_reg_write),
      .id_rd_addr(id_rd_addr), .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
      .id_shamt(id_shamt), .id_alu_src_imm(id_alu_src_imm), .id_imm_zext(id_imm_zext),
      .id_shift_shamt(id_shift_shamt),
      .exm_reg_write(exm_reg_write), .exm_rd_addr(exm_rd_addr), .exm_result(exm_result),
      .mwb_reg_write(mwb_reg_write), .mwb_rd_addr(mwb_rd_addr), .mwb_data(mwb_data),
      .ex_valid(ex_valid), .ex_oprd1(ex_oprd1), .ex_oprd2(ex_oprd2),
      .ex_option(ex_option), .ex_rd_addr(ex_rd_addr), .ex_reg_write(ex_reg_write),
      .ex_store_data(ex_store_data)
   );

   typedef struct {
      logic        valid;
      logic [3:0]  alu_op;
      logic        reg_write;
      logic [4:0]  rd, rs, rt;
      logic [31:0] rs_data, rt_data;
      logic [15:0] imm;
      logic [4:0]  shamt;
      logic        src_imm, zext, shift;
      logic        exm_we;
      logic [4:0]  exm_rd;
      logic [31:0] exm_res;
      logic        mwb_we;
      logic [4:0]  mwb_rd;
      logic [31:0] mwb_dat;
      logic        e_valid, e_rw;
      logic [3:0]  e_opt;
      logic [31:0] e_oprd1, e_oprd2, e_store;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply(input vec_t v);
      id_valid = v.valid;        id_alu_op = v.alu_op;     id_reg_write = v.reg_write;
      id_rd_addr = v.rd;         id_rs_addr = v.rs;        id_rt_addr = v.rt;
      id_rs_data = v.rs_data;    id_rt_data = v.rt_data;   id_imm = v.imm;
      id_shamt = v.shamt;        id_alu_src_imm = v.src_imm;
      id_imm_zext = v.zext;      id_shift_shamt = v.shift;
      exm_reg_write = v.exm_we;  exm_rd_addr = v.exm_rd;   exm_result = v.exm_res;
      mwb_reg_write = v.mwb_we;  mwb_rd_addr = v.mwb_rd;   mwb_data = v.mwb_dat;
   endtask

   task automatic check_vec(input string tag, input vec_t v);
      chk({tag, "_valid"}, {31'b0, ex_valid}, {31'b0, v.e_valid});
      chk({tag, "_reg_write"}, {31'b0, ex_reg_write}, {31'b0, v.e_rw});
      chk({tag, "_option"}, {28'b0, ex_option}, {28'b0, v.e_opt});
      chk({tag, "_rd_addr"}, {27'b0, ex_rd_addr}, {27'b0, v.rd});
      chk({tag, "_oprd1"}, ex_oprd1, v.e_oprd1);
      chk({tag, "_oprd2"}, ex_oprd2, v.e_oprd2);
      chk({tag, "_store"}, ex_store_data, v.e_store);
   endtask

   task automatic check_bubble(input string tag);
      chk({tag, "_valid"}, {31'b0, ex_valid}, 32'd0);
      chk({tag, "_reg_write"}, {31'b0, ex_reg_write}, 32'd0);
      chk({tag, "_option"}, {28'b0, ex_option}, 32'd0);
      chk({tag, "_oprd1"}, ex_oprd1, 32'd0);
      chk({tag, "_oprd2"}, ex_oprd2, 32'd0);
      chk({tag, "_store"}, ex_store_data, 32'd0);
   endtask

   initial begin
      // valid op rw rd rs rt rs_data rt_data imm shamt src zext shift | exm | mwb | expected
      vecs[0] = '{1, 4'h2, 1, 5'd7, 5'd1, 5'd2, 32'd5, 32'd9, 16'hFFFE, 5'd0, 1, 0, 0,
                  0, 5'd0, 32'd0, 0, 5'd0, 32'd0,
                  1, 1, 4'h2, 32'd5, 32'hFFFF_FFFE, 32'd9};
      vecs[1] = '{1, 4'h3, 1, 5'd7, 5'd1, 5'd2, 32'd5, 32'd9, 16'hFFFE, 5'd0, 1, 1, 0,
                  0, 5'd0, 32'd0, 0, 5'd0, 32'd0,
                  1, 1, 4'h3, 32'd5, 32'h0000_FFFE, 32'd9};
      vecs[2] = '{1, 4'h4, 1, 5'd8, 5'd3, 5'd4, 32'd1, 32'h10, 16'h0, 5'd0, 0, 0, 0,
                  1, 5'd3, 32'hAA, 1, 5'd3, 32'hBB,
                  1, 1, 4'h4, (FWD ? 32'hAA : 32'h1), 32'h10, 32'h10};
      vecs[3] = '{1, 4'h4, 1, 5'd8, 5'd3, 5'd4, 32'd1, 32'h10, 16'h0, 5'd0, 0, 0, 0,
                  0, 5'd3, 32'hAA, 1, 5'd3, 32'hBB,
                  1, 1, 4'h4, (FWD ? 32'hBB : 32'h1), 32'h10, 32'h10};
      vecs[4] = '{1, 4'h1, 1, 5'd9, 5'd0, 5'd4, 32'h55, 32'h10, 16'h0, 5'd0, 0, 0, 0,
                  1, 5'd0, 32'h77, 1, 5'd0, 32'h66,
                  1, 1, 4'h1, 32'h55, 32'h10, 32'h10};
      vecs[5] = '{1, 4'hA, 1, 5'd10, 5'd6, 5'd2, 32'h123, 32'h8000_0000, 16'h1234, 5'd4, 1, 0, 1,
                  0, 5'd0, 32'd0, 0, 5'd0, 32'd0,
                  1, 1, 4'hA, 32'h8000_0000, 32'd4, 32'h8000_0000};
      vecs[6] = '{0, 4'h5, 1, 5'd11, 5'd1, 5'd2, 32'h20, 32'h30, 16'h0, 5'd0, 0, 0, 0,
                  0, 5'd0, 32'd0, 0, 5'd0, 32'd0,
                  0, 0, 4'h5, 32'h20, 32'h30, 32'h30};
      vecs[7] = '{1, 4'h6, 1, 5'd12, 5'd1, 5'd5, 32'h21, 32'h1, 16'h0, 5'd0, 0, 0, 0,
                  0, 5'd0, 32'd0, 1, 5'd5, 32'hCC,
                  1, 1, 4'h6, 32'h21, (FWD ? 32'hCC : 32'h1), (FWD ? 32'hCC : 32'h1)};
      vecs[8] = '{1, 4'h7, 0, 5'd13, 5'd3, 5'd4, 32'h44, 32'h45, 16'h8000, 5'd0, 1, 1, 0,
                  0, 5'd0, 32'd0, 0, 5'd0, 32'd0,
                  1, 0, 4'h7, 32'h44, 32'h0000_8000, 32'h45};

      rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
      apply(vecs[0]);
      #12;
      check_bubble("reset");
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         apply(vecs[i]);
         step();
         check_vec($sformatf("vec%0d", i), vecs[i]);
      end

      // Stage holds vecs[8] while the decode side keeps changing
      stall = 1'b1;
      for (int c = 0; c < 3; c++) begin
         apply(vecs[c]);
         exm_reg_write = 1'b0; mwb_reg_write = 1'b0;
         step();
         check_vec($sformatf("stall%0d", c), vecs[8]);
      end

      exm_reg_write = 1'b1; exm_rd_addr = 5'd3; exm_result = 32'h99;
      #1;
      chk("stall_fwd_a", ex_oprd1, FWD ? 32'h99 : 32'h44);
      step();
      exm_result = 32'h9A;
      #1;
      chk("stall_fwd_b", ex_oprd1, FWD ? 32'h9A : 32'h44);
      chk("stall_fwd_opt", {28'b0, ex_option}, 32'h7);

      flush = 1'b1;
      step();
      check_bubble("stall_flush");
      flush = 1'b0; stall = 1'b0;
      exm_reg_write = 1'b0; exm_rd_addr = 5'd0; exm_result = 32'h0;

      apply(vecs[0]);
      step();
      check_vec("pre_rst", vecs[0]);
      stall = 1'b1;
      #3;
      rst_n = 1'b0;
      #1;
      check_bubble("async_rst");
      stall = 1'b0; flush = 1'b1;
      step();
      check_bubble("rst_hold");
      rst_n = 1'b1; flush = 1'b0;
      step();
      check_vec("post_rst", vecs[0]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
